// File: rtl/dmem_dump_pkg.sv
// Shared state encoding and word geometry for the data-memory dump reader.
package dmem_dump_pkg;

   localparam int unsigned STATE_WIDTH = 3;
   localparam int unsigned WORD_BYTES  = 4;

   typedef enum logic [STATE_WIDTH-1:0] {
      IDLE    = 3'd0,
      ISSUE   = 3'd1,
      WAIT    = 3'd2,
      PRESENT = 3'd3,
      FINISH  = 3'd4
   } dump_state_t;

endpackage : dmem_dump_pkg

// File: rtl/dmem_dump_reader_if.sv
// Memory read port plus word output stream of the dump reader.
interface dmem_dump_reader_if #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32
) ();

   logic [ADDR_WIDTH-1:0] mem_addr;
   logic                  mem_rd_en;
   logic [DATA_WIDTH-1:0] mem_rdata;
   logic                  out_valid;
   logic                  out_ready;
   logic [ADDR_WIDTH-1:0] out_addr;
   logic [DATA_WIDTH-1:0] out_data;

   // Reader side: drives the memory read strobe and presents words.
   modport master (
      output mem_addr, mem_rd_en,
      input  mem_rdata,
      output out_valid, out_addr, out_data,
      input  out_ready
   );

   // Memory/consumer side.
   modport slave (
      input  mem_addr, mem_rd_en,
      output mem_rdata,
      input  out_valid, out_addr, out_data,
      output out_ready
   );

endinterface : dmem_dump_reader_if

// File: rtl/dmem_dump_reader.sv
// Walks a word-aligned window of data memory and streams (addr, word) pairs.
// One read is in flight at a time: no read-ahead, so mem_rd_en and out_valid
// are never high together. All outputs are registered from next-state values.
module dmem_dump_reader
   import dmem_dump_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH  = 32,
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned COUNT_WIDTH = 16,
   parameter int unsigned MEM_LATENCY = 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [ADDR_WIDTH-1:0]  base_addr,
   input  logic [COUNT_WIDTH-1:0] word_count,
   dmem_dump_reader_if.master     bus,
   output logic                   busy,
   output logic                   done
);

   localparam int unsigned LAT_WIDTH = 2;

   dump_state_t            state, state_nxt;
   logic [ADDR_WIDTH-1:0]  addr, addr_nxt;
   logic [COUNT_WIDTH-1:0] remaining, remaining_nxt;
   logic [LAT_WIDTH-1:0]   lat_cnt, lat_cnt_nxt;
   logic [ADDR_WIDTH-1:0]  mem_addr_nxt;
   logic                   mem_rd_en_nxt;
   logic                   out_valid_nxt;
   logic [ADDR_WIDTH-1:0]  out_addr_nxt;
   logic [DATA_WIDTH-1:0]  out_data_nxt;
   logic                   busy_nxt;
   logic                   done_nxt;

   logic [ADDR_WIDTH-1:0]  base_aligned_c;
   logic [ADDR_WIDTH-1:0]  addr_inc_c;

   assign base_aligned_c = base_addr & ~ADDR_WIDTH'(WORD_BYTES - 1);
   assign addr_inc_c     = addr + ADDR_WIDTH'(WORD_BYTES);

   // State, counters and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         addr          <= '0;
         remaining     <= '0;
         lat_cnt       <= '0;
         bus.mem_addr  <= '0;
         bus.mem_rd_en <= 1'b0;
         bus.out_valid <= 1'b0;
         bus.out_addr  <= '0;
         bus.out_data  <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
      end else begin
         state         <= state_nxt;
         addr          <= addr_nxt;
         remaining     <= remaining_nxt;
         lat_cnt       <= lat_cnt_nxt;
         bus.mem_addr  <= mem_addr_nxt;
         bus.mem_rd_en <= mem_rd_en_nxt;
         bus.out_valid <= out_valid_nxt;
         bus.out_addr  <= out_addr_nxt;
         bus.out_data  <= out_data_nxt;
         busy          <= busy_nxt;
         done          <= done_nxt;
      end
   end

   // Next-state and next-output logic; strobes are computed one cycle ahead.
   always_comb begin
      state_nxt     = state;
      addr_nxt      = addr;
      remaining_nxt = remaining;
      lat_cnt_nxt   = lat_cnt;
      mem_addr_nxt  = bus.mem_addr;
      mem_rd_en_nxt = 1'b0;
      out_valid_nxt = bus.out_valid;
      out_addr_nxt  = bus.out_addr;
      out_data_nxt  = bus.out_data;
      busy_nxt      = busy;
      done_nxt      = 1'b0;

      unique case (state)
         IDLE: begin
            if (start) begin
               busy_nxt = 1'b1;
               if (word_count != '0) begin
                  addr_nxt      = base_aligned_c;
                  remaining_nxt = word_count;
                  mem_addr_nxt  = base_aligned_c;
                  mem_rd_en_nxt = 1'b1;
                  state_nxt     = ISSUE;
               end else begin
                  done_nxt  = 1'b1;
                  state_nxt = FINISH;
               end
            end
         end

         ISSUE: begin
            lat_cnt_nxt = LAT_WIDTH'(MEM_LATENCY - 1);
            state_nxt   = WAIT;
         end

         WAIT: begin
            if (lat_cnt == '0) begin
               out_data_nxt  = bus.mem_rdata;
               out_addr_nxt  = addr;
               out_valid_nxt = 1'b1;
               state_nxt     = PRESENT;
            end else begin
               lat_cnt_nxt = lat_cnt - LAT_WIDTH'(1);
            end
         end

         PRESENT: begin
            if (bus.out_valid && bus.out_ready) begin
               out_valid_nxt = 1'b0;
               remaining_nxt = remaining - COUNT_WIDTH'(1);
               addr_nxt      = addr_inc_c;
               if (remaining != COUNT_WIDTH'(1)) begin
                  mem_addr_nxt  = addr_inc_c;
                  mem_rd_en_nxt = 1'b1;
                  state_nxt     = ISSUE;
               end else begin
                  done_nxt  = 1'b1;
                  state_nxt = FINISH;
               end
            end
         end

         FINISH: begin
            busy_nxt  = 1'b0;
            state_nxt = IDLE;
         end

         default: begin
            busy_nxt  = 1'b0;
            state_nxt = IDLE;
         end
      endcase
   end

endmodule : dmem_dump_reader

// File: tb/tb_dmem_dump_reader.sv
// Directed bench for dmem_dump_reader with a latency-1 synchronous memory model.
module tb_dmem_dump_reader;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic [31:0] base_addr = '0;
   logic [15:0] word_count = '0;
   logic        busy;
   logic        done;

   int checks = 0;
   int errors = 0;

   logic [31:0] mem [64];
   logic [5:0]  rd_idx;

   // Per-run observations.
   logic [31:0] rd_addr_q  [$];
   logic [31:0] acc_addr_q [$];
   logic [31:0] acc_data_q [$];
   int          overlap, rd_before_first, busy_pre, busy_total, done_n, done_cyc;
   int          acc_cyc, stalled, unstable, valid_n;
   logic [31:0] hold_addr, hold_data, final_data;
   logic        final_valid;

   dmem_dump_reader_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

   dmem_dump_reader #(
      .ADDR_WIDTH (32),
      .DATA_WIDTH (32),
      .COUNT_WIDTH(16),
      .MEM_LATENCY(1)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .base_addr (base_addr),
      .word_count(word_count),
      .bus       (bus),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   // Synchronous read memory, one cycle latency.
   assign rd_idx = bus.mem_addr[7:2];
   always @(posedge clk) begin
      if (bus.mem_rd_en) bus.mem_rdata <= mem[rd_idx];
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Start a dump and observe it cycle by cycle at the falling edge.
   task automatic run_dump(input logic [31:0] base, input logic [15:0] cnt, input int stall);
      int stall_left;
      rd_addr_q.delete(); acc_addr_q.delete(); acc_data_q.delete();
      overlap = 0; rd_before_first = 0; busy_pre = 0; busy_total = 0; done_n = 0;
      done_cyc = -1; acc_cyc = -1; stalled = 0; unstable = 0; valid_n = 0;
      stall_left = stall;
      @(negedge clk);
      start = 1'b1; base_addr = base; word_count = cnt; bus.out_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int c = 0; c < 200; c++) begin
         if (bus.mem_rd_en) begin
            rd_addr_q.push_back(bus.mem_addr);
            if (bus.out_valid) overlap++;
            if (acc_addr_q.size() == 0) rd_before_first++;
         end
         if (busy) busy_total++;
         if (busy && !done && done_cyc < 0) busy_pre++;
         if (done) begin
            done_n++;
            if (done_cyc < 0) done_cyc = c;
         end
         if (bus.out_valid) begin
            valid_n++;
            if (stall_left > 0) begin
               if (stall_left == stall) begin
                  hold_addr = bus.out_addr;
                  hold_data = bus.out_data;
               end else if (bus.out_addr !== hold_addr || bus.out_data !== hold_data) begin
                  unstable++;
               end
               stall_left--;
               stalled++;
               bus.out_ready = 1'b0;
            end else begin
               if (stall > 0 && acc_addr_q.size() == 0 &&
                   (bus.out_addr !== hold_addr || bus.out_data !== hold_data)) unstable++;
               bus.out_ready = 1'b1;
               acc_addr_q.push_back(bus.out_addr);
               acc_data_q.push_back(bus.out_data);
               acc_cyc = c;
            end
         end else begin
            bus.out_ready = 1'b1;
         end
         if (done_cyc >= 0 && c >= done_cyc + 2) break;
         @(negedge clk);
      end
      final_data  = bus.out_data;
      final_valid = bus.out_valid;
      if (done_cyc < 0) chk("done_timeout", 64'(done_n), 64'd1);
   endtask

   function automatic logic [31:0] qget(input logic [31:0] q [$], input int i);
      return (i < q.size()) ? q[i] : 32'hDEAD_BEEF;
   endfunction

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = 32'hA500_0000 | 32'(i);
      mem[16] = 32'h1111_1111;
      mem[17] = 32'h2222_2222;
      mem[18] = 32'h3333_3333;
      bus.out_ready = 1'b1;

      // Asynchronous reset before any clock edge matters.
      #2 rst = 1'b1;
      #1;
      chk("rst_busy",     64'(busy), 64'd0);
      chk("rst_done",     64'(done), 64'd0);
      chk("rst_rd_en",    64'(bus.mem_rd_en), 64'd0);
      chk("rst_valid",    64'(bus.out_valid), 64'd0);
      chk("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
      chk("rst_out_data", 64'(bus.out_data), 64'd0);
      @(negedge clk); @(negedge clk);
      rst = 1'b0;

      // Three words from 0x40 with ready high.
      run_dump(32'h40, 16'd3, 0);
      chk("t1_nacc",  64'(acc_addr_q.size()), 64'd3);
      chk("t1_a0",    64'(qget(acc_addr_q, 0)), 64'h40);
      chk("t1_d0",    64'(qget(acc_data_q, 0)), 64'h1111_1111);
      chk("t1_a1",    64'(qget(acc_addr_q, 1)), 64'h44);
      chk("t1_d1",    64'(qget(acc_data_q, 1)), 64'h2222_2222);
      chk("t1_a2",    64'(qget(acc_addr_q, 2)), 64'h48);
      chk("t1_d2",    64'(qget(acc_data_q, 2)), 64'h3333_3333);
      chk("t1_ndone", 64'(done_n), 64'd1);
      chk("t1_done_lag", 64'(done_cyc - acc_cyc), 64'd1);
      chk("t1_busy9", 64'(busy_pre), 64'd9);
      chk("t1_nrd",   64'(rd_addr_q.size()), 64'd3);
      chk("t1_overlap", 64'(overlap), 64'd0);
      chk("t1_keep_data", 64'(final_data), 64'h3333_3333);
      chk("t1_valid_low", 64'(final_valid), 64'd0);

      // Zero-length dump.
      run_dump(32'h100, 16'd0, 0);
      chk("t2_nrd",    64'(rd_addr_q.size()), 64'd0);
      chk("t2_nvalid", 64'(valid_n), 64'd0);
      chk("t2_done_cyc", 64'(done_cyc), 64'd0);
      chk("t2_ndone",  64'(done_n), 64'd1);
      chk("t2_busy1",  64'(busy_total), 64'd1);

      // Unaligned base is forced to word alignment.
      run_dump(32'h43, 16'd1, 0);
      chk("t3_mem_addr", 64'(qget(rd_addr_q, 0)), 64'h40);
      chk("t3_out_addr", 64'(qget(acc_addr_q, 0)), 64'h40);
      chk("t3_out_data", 64'(qget(acc_data_q, 0)), 64'h1111_1111);

      // Backpressure on the first word.
      run_dump(32'h44, 16'd2, 5);
      chk("t4_stalled",  64'(stalled), 64'd5);
      chk("t4_unstable", 64'(unstable), 64'd0);
      chk("t4_rd_first", 64'(rd_before_first), 64'd1);
      chk("t4_a0", 64'(qget(acc_addr_q, 0)), 64'h44);
      chk("t4_d0", 64'(qget(acc_data_q, 0)), 64'h2222_2222);
      chk("t4_a1", 64'(qget(acc_addr_q, 1)), 64'h48);
      chk("t4_d1", 64'(qget(acc_data_q, 1)), 64'h3333_3333);
      chk("t4_busy", 64'(busy_pre), 64'd11);
      chk("t4_overlap", 64'(overlap), 64'd0);

      // Address wraps past the top of the space.
      run_dump(32'hFFFF_FFFC, 16'd2, 0);
      chk("t5_rd0", 64'(qget(rd_addr_q, 0)), 64'hFFFF_FFFC);
      chk("t5_rd1", 64'(qget(rd_addr_q, 1)), 64'h0);
      chk("t5_d0",  64'(qget(acc_data_q, 0)), 64'hA500_003F);
      chk("t5_d1",  64'(qget(acc_data_q, 1)), 64'hA500_0000);
      chk("t5_ndone", 64'(done_n), 64'd1);

      // Reset in WAIT of word 2 of 4 abandons the dump.
      @(negedge clk);
      start = 1'b1; base_addr = 32'h0; word_count = 16'd4; bus.out_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      chk("t6_wait_addr",  64'(bus.mem_addr), 64'h4);
      chk("t6_wait_rd_en", 64'(bus.mem_rd_en), 64'd0);
      chk("t6_wait_busy",  64'(busy), 64'd1);
      #1 rst = 1'b1;
      #1;
      chk("t6_busy",     64'(busy), 64'd0);
      chk("t6_mem_addr", 64'(bus.mem_addr), 64'd0);
      chk("t6_out_addr", 64'(bus.out_addr), 64'd0);
      chk("t6_out_data", 64'(bus.out_data), 64'd0);
      chk("t6_valid",    64'(bus.out_valid), 64'd0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("t6_no_done", 64'(done), 64'd0);
      end
      rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("t6_idle_done", 64'(done), 64'd0);
      end
      run_dump(32'h0, 16'd1, 0);
      chk("t6_a0",    64'(qget(acc_addr_q, 0)), 64'h0);
      chk("t6_d0",    64'(qget(acc_data_q, 0)), 64'hA500_0000);
      chk("t6_ndone", 64'(done_n), 64'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_dmem_dump_reader
